// File: rtl/rv32m_seq_divider_if.sv
// Request/response bundle between the execute-stage pipeline and the sequential divider.
interface rv32m_seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  // Pipeline side: issues requests, consumes results.
  modport master (
    output in_valid, op, dividend, divisor, out_ready,
    input  in_ready, out_valid, result
  );

  // Divider side.
  modport slave (
    input  in_valid, op, dividend, divisor, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/rv32m_seq_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU: restoring shift-subtract, one quotient bit per cycle.
module rv32m_seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  rv32m_seq_divider_if.slave    dv
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             rem_sel_q, rem_sel_d;   // 1: remainder requested
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;         // raw dividend for special results
  logic [WIDTH-1:0] dvsr_q, dvsr_d;         // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Datapath helpers; the shifted remainder carries an extra bit so the trial sign survives.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, trial;

  assign dv.in_ready  = in_ready_q;
  assign dv.out_valid = out_valid_q;
  assign dv.result    = result_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_sel_q   <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvnd_q      <= '0;
      dvsr_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_sel_q   <= rem_sel_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dvnd_q      <= dvnd_d;
      dvsr_q      <= dvsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, iteration step and result fix-up.
  always_comb begin
    state_d     = state_q;
    rem_sel_d   = rem_sel_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dvnd_d      = dvnd_q;
    dvsr_d      = dvsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    a_neg  = ~dv.op[0] & dv.dividend[WIDTH-1];
    b_neg  = ~dv.op[0] & dv.divisor[WIDTH-1];
    a_mag  = a_neg ? -dv.dividend : dv.dividend;
    b_mag  = b_neg ? -dv.divisor : dv.divisor;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr_q};

    unique case (state_q)
      S_IDLE: begin
        if (dv.in_valid) begin
          in_ready_d = 1'b0;
          rem_sel_d  = dv.op[1];
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dvnd_d     = dv.dividend;
          dvsr_d     = b_mag;
          quo_d      = a_mag;
          rem_d      = '0;
          cnt_d      = '0;
          div0_d     = (dv.divisor == '0);
          ovf_d      = ~dv.op[0] && (dv.dividend == MIN_NEG) && (dv.divisor == '1);
          state_d    = (div0_d || ovf_d) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (div0_q) begin
          result_d = rem_sel_q ? dvnd_q : '1;
        end else if (ovf_q) begin
          result_d = rem_sel_q ? '0 : dvnd_q;
        end else if (rem_sel_q) begin
          result_d = neg_rem_q ? -rem_q : rem_q;
        end else begin
          result_d = neg_quo_q ? -quo_q : quo_q;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (dv.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32m_seq_divider.sv
// Directed checks for the sequential RV32M divider: results, latency, handshake and reset.
module tb_rv32m_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  rv32m_seq_divider_if #(.WIDTH(32)) bus ();

  rv32m_seq_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .dv  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency from the accept edge, optionally stall, then retire.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat, input int hold);
    int lat;
    logic [31:0] first_res;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h0;
    bus.op       = ~o;
    chk({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 100);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, bus.result, exp_res);
    first_res = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_result"}, bus.result, first_res);
      chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_retire_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_retire_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.dividend  = 32'h0;
    bus.divisor   = 32'h0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op("div_100_7",   2'b00, 32'd100,       32'd7,         32'd14,        33, 0);
    do_op("rem_100_7",   2'b10, 32'd100,       32'd7,         32'd2,         33, 0);
    do_op("div_m100_7",  2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  33, 0);
    do_op("rem_m100_7",  2'b10, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  33, 0);
    do_op("rem_100_m7",  2'b10, 32'd100,       32'hFFFFFFF9,  32'd2,         33, 0);
    do_op("div_100_m7",  2'b00, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  33, 0);
    do_op("divu_max_2",  2'b01, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  33, 0);
    do_op("remu_max_2",  2'b11, 32'hFFFFFFFF,  32'd2,         32'd1,         33, 0);
    do_op("divu_by0",    2'b01, 32'h12345678,  32'd0,         32'hFFFFFFFF,  1,  0);
    do_op("rem_by0",     2'b10, 32'h12345678,  32'd0,         32'h12345678,  1,  0);
    do_op("div_ovf",     2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1,  0);
    do_op("rem_ovf",     2'b10, 32'h80000000,  32'hFFFFFFFF,  32'h0,         1,  0);
    do_op("div_hold",    2'b00, 32'd1000,      32'd10,        32'd100,       33, 10);

    // Abort an operation mid-iteration with reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.dividend = 32'd500;
    bus.divisor  = 32'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midcalc_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midcalc_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midcalc_rst_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midcalc_rst_no_output", 32'(seen), 32'd0);

    do_op("div_9_3", 2'b00, 32'd9, 32'd3, 32'd3, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
